// File: rtl/uart_rx.sv
// 8-bit UART receiver, start/8 data LSB-first/[even parity]/stop, 2-flop input synchronizer.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_HIGH
   } state_t;

   state_t          state, state_nxt;
   logic            rx_meta, rx_s;
   logic [TW-1:0]   timer, timer_nxt;
   logic [2:0]      bit_idx, idx_nxt;
   logic [7:0]      shift, shift_nxt;
   logic [7:0]      data_nxt;
   logic            valid_nxt, ferr_nxt, perr_nxt;
   logic            tick_half, tick_full;
   logic            parity_ok;

   assign tick_half = (timer == HALF_LAST);
   assign tick_full = (timer == FULL_LAST);

   // Input synchronizer; idles high so reset does not look like a start bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic parity_bit, par_nxt;
   assign parity_ok = ~(^shift ^ parity_bit);
`else
   assign parity_ok  = 1'b1;
   assign parity_err = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (!rx_s) state_nxt = START;
         START:     if (tick_half) state_nxt = rx_s ? IDLE : DATA;
         DATA: begin
            if (tick_full && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY:    if (tick_full) state_nxt = STOP;
`endif
         STOP:      if (tick_full) state_nxt = rx_s ? IDLE : WAIT_HIGH;
         WAIT_HIGH: if (rx_s) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      timer_nxt = timer + TW'(1);
      idx_nxt   = bit_idx;
      shift_nxt = shift;
      data_nxt  = data;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;
      perr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_nxt   = parity_bit;
`endif
      case (state)
         IDLE: begin
            timer_nxt = '0;
            idx_nxt   = 3'd0;
         end
         START: begin
            if (tick_half) begin
               timer_nxt = '0;
               idx_nxt   = 3'd0;
            end
         end
         DATA: begin
            if (tick_full) begin
               timer_nxt          = '0;
               shift_nxt[bit_idx] = rx_s;
               idx_nxt            = bit_idx + 3'd1;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick_full) begin
               timer_nxt = '0;
               par_nxt   = rx_s;
            end
         end
`endif
         STOP: begin
            if (tick_full) begin
               timer_nxt = '0;
               if (!rx_s) begin
                  ferr_nxt = 1'b1;
               end else if (!parity_ok) begin
                  perr_nxt = 1'b1;
               end else begin
                  data_nxt  = shift;
                  valid_nxt = 1'b1;
               end
            end
         end
         default: timer_nxt = '0;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer     <= '0;
         bit_idx   <= 3'd0;
         shift     <= 8'h00;
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         timer     <= timer_nxt;
         bit_idx   <= idx_nxt;
         shift     <= shift_nxt;
         data      <= data_nxt;
         valid     <= valid_nxt;
         frame_err <= ferr_nxt;
         busy      <= (state_nxt != IDLE);
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_bit <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         parity_bit <= par_nxt;
         parity_err <= perr_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against
// a frame-level model that predicts each report's kind, data and cycle.
module tb_uart_rx;

   localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned PAR = 1;
`else
   localparam int unsigned PAR = 0;
`endif
   // start edge -> 2 sync + 1 detect, half a start bit, then data/[parity]/stop bits
   localparam int LAT = 3 + CPB / 2 + CPB * (9 + PAR);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data;
   logic       valid, frame_err, parity_err, busy;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
      .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      int         kind;   // 0 valid, 1 frame_err, 2 parity_err
      logic [7:0] d;
   } ev_t;

   ev_t        obs_q[$];
   ev_t        exp_q[$];
   logic [7:0] last_good = 8'h00;
   int         n_cmp = 0;
   int         n_bad = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (valid)      obs_q.push_back(ev_t'{cyc, 0, data});
         if (frame_err)  obs_q.push_back(ev_t'{cyc, 1, data});
         if (parity_err) obs_q.push_back(ev_t'{cyc, 2, data});
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic hold_rx(input logic v, input int n);
      rx = v;
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   function automatic logic even_par(input logic [7:0] b);
      return ^b;
   endfunction

   // Drives one frame and records the model's predicted report for it
   task automatic send_frame(input logic [7:0] b, input logic stopb, input logic parb, input int extra);
      int kind;
      if (!stopb)                                   kind = 1;
      else if (PAR != 0 && ((^b) ^ parb) == 1'b1)   kind = 2;
      else                                          kind = 0;
      if (kind == 0) last_good = b;
      exp_q.push_back(ev_t'{cyc + LAT, kind, last_good});
      hold_rx(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold_rx(b[i], CPB);
      if (PAR != 0) hold_rx(parb, CPB);
      hold_rx(stopb, CPB + extra);
   endtask

   task automatic check_events(input string tag);
      repeat (4) @(posedge clk);
      #1;
      chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         chk($sformatf("%s_%0d_cyc", tag, i),  32'(obs_q[i].cyc),  32'(exp_q[i].cyc));
         chk($sformatf("%s_%0d_kind", tag, i), 32'(obs_q[i].kind), 32'(exp_q[i].kind));
         chk($sformatf("%s_%0d_data", tag, i), 32'(obs_q[i].d),    32'(exp_q[i].d));
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [7:0] b;
      logic       sb, pb;
      int         gap;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", 32'(data), 32'h00);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_ferr", 32'(frame_err), 32'h0);
      chk("rst_perr", 32'(parity_err), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      hold_rx(1'b1, 5);

      // Good 0xA5
      send_frame(8'hA5, 1'b1, even_par(8'hA5), 0);
      hold_rx(1'b1, 20);
      check_events("a5");
      chk("a5_busy", 32'(busy), 32'h0);
      chk("a5_data", 32'(data), 32'hA5);

      // Short start glitch is rejected, then 0x3C
      hold_rx(1'b0, 4);
      hold_rx(1'b1, 30);
      check_events("glitch");
      chk("glitch_busy", 32'(busy), 32'h0);
      send_frame(8'h3C, 1'b1, even_par(8'h3C), 0);
      hold_rx(1'b1, 20);
      check_events("3c");

      // Stop bit low, line held low 40 cycles from the stop bit onward
      send_frame(8'h5A, 1'b0, even_par(8'h5A), 40 - CPB);
      chk("ferr_busy_held", 32'(busy), 32'h1);
      hold_rx(1'b1, 200);
      check_events("ferr");
      chk("ferr_data", 32'(data), 32'h3C);
      chk("ferr_busy", 32'(busy), 32'h0);

      // Reset during data bit 3 of 0xFF, then 0x81
      hold_rx(1'b0, CPB);
      for (int i = 0; i < 3; i++) hold_rx(1'b1, CPB);
      hold_rx(1'b1, CPB / 2);
      chk("abort_busy_pre", 32'(busy), 32'h1);
      rst = 1'b1;
      #1;
      chk("abort_busy_rst", 32'(busy), 32'h0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      hold_rx(1'b1, 2 * CPB);
      check_events("abort");
      send_frame(8'h81, 1'b1, even_par(8'h81), 0);
      hold_rx(1'b1, 20);
      check_events("81");
      chk("81_data", 32'(data), 32'h81);

      // Back-to-back 0x00 then 0xFF
      send_frame(8'h00, 1'b1, even_par(8'h00), 0);
      send_frame(8'hFF, 1'b1, even_par(8'hFF), 0);
      hold_rx(1'b1, 4);
      if (obs_q.size() >= 2)
         chk("b2b_gap", 32'(obs_q[1].cyc - obs_q[0].cyc), 32'((10 + PAR) * CPB));
      else
         chk("b2b_pulses", 32'(obs_q.size()), 32'd2);
      check_events("b2b");

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1, 0);
      hold_rx(1'b1, 20);
      check_events("par_good");
      send_frame(8'h07, 1'b1, 1'b0, 0);
      hold_rx(1'b1, 20);
      check_events("par_bad");
      chk("par_bad_data", 32'(data), 32'h07);
`endif

      // Random frames: mixed stop/parity errors, random idle gaps
      for (int n = 0; n < 16; n++) begin
         b  = 8'($urandom);
         sb = ($urandom_range(0, 4) != 0);
         pb = even_par(b) ^ ($urandom_range(0, 3) == 0);
         gap = sb ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 12));
         send_frame(b, sb, pb, 0);
         hold_rx(1'b1, gap);
      end
      hold_rx(1'b1, 20);
      check_events("rand");
      chk("rand_busy", 32'(busy), 32'h0);
      chk("rand_data", 32'(data), 32'(last_good));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 4..4095.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 rx  input  1  asynchronous serial line; idle high; frame is start(0), 8 data bits LSB first, [parity], stop(1).
REQ-005 data  output  8  last correctly received byte; held until the next good frame.
REQ-006 valid  output  1  one-cycle pulse; data is new on this cycle.
REQ-007 frame_err  output  1  one-cycle pulse; stop bit was sampled low.
REQ-008 parity_err  output  1  one-cycle pulse; parity mismatch (see Configuration).
REQ-009 busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rx_s). Input-to-rx_s latency is 2 cycles.
REQ-011 The FSM SHALL have these states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-012 IDLE: when rx_s==0, go to START and clear the bit-timer to 0.
REQ-013 START: at bit-timer == CLKS_PER_BIT/2-1 (integer division), sample rx_s. If 0, clear the timer and go to DATA with bit index 0. If 1, treat it as a glitch and return to IDLE with no output pulse.
REQ-014 DATA: at bit-timer == CLKS_PER_BIT-1, sample rx_s into shift-register bit [index] (LSB first) and clear the timer. After index 7, go to PARITY if parity is enabled, else go to STOP.
REQ-015 PARITY: at bit-timer == CLKS_PER_BIT-1, sample the parity bit, clear the timer, go to STOP.
REQ-016 STOP: at bit-timer == CLKS_PER_BIT-1, sample rx_s.
  - If 1 and parity is OK: load data from the shift register, pulse valid on the next cycle, go to IDLE.
  - If 1 and parity is bad: pulse parity_err, leave data unchanged, go to IDLE.
  - If 0: pulse frame_err (takes priority over parity_err), leave data unchanged, go to WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until rx_s==1, then go to IDLE; a break condition or held-low line SHALL NOT start a new frame.
REQ-018 valid, frame_err and parity_err SHALL each be high for exactly one clock per frame. At most one of the three is high per frame, and none is high for a rejected start glitch.
REQ-019 The bit-timer SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and SHALL never wrap past CLKS_PER_BIT-1.
REQ-020 A falling edge on rx_s while in START/DATA/PARITY/STOP SHALL be ignored (no resynchronization mid-frame).
REQ-021 Back-to-back frames: a start bit arriving immediately after the stop-bit sample SHALL be accepted. IDLE is re-entered the cycle after the STOP sample.

Reset
REQ-022 While rst is high: state=IDLE, timer=0, bit index=0, shift register=0, data=8'h00, valid=0, frame_err=0, parity_err=0, busy=0, both synchronizer flops=1.
REQ-023 Assertion of rst mid-frame SHALL abort the frame immediately with no output pulse. After release, reception SHALL resume only on a new falling edge of rx_s.

Configuration
REQ-024 Macro UART_RX_PARITY_EN.
  - Defined: frame includes an even-parity bit after bit 7; PARITY state is used; a mismatch (XOR of 8 data bits and parity bit == 1) produces a parity_err pulse and no valid.
  - Undefined: PARITY state and checker are not compiled; DATA goes directly to STOP; parity_err is tied to 0; the frame is 10 bits.

Verification (CLKS_PER_BIT=16)
REQ-025 Receive byte 0xA5 with a good stop bit -> data=0xA5, valid high for exactly 1 cycle, frame_err=0, busy low again after the frame.
REQ-026 Drive rx low for 4 cycles, then high -> no valid, no error pulse, FSM back in IDLE; a following 0x3C frame is received correctly.
REQ-027 Receive 0x5A with the stop bit driven 0 and held low for 40 cycles -> frame_err pulses once, data keeps its previous value, no new frame starts until rx returns high.
REQ-028 Assert rst during data bit 3 of a 0xFF frame, release, then send 0x81 -> no pulse for the aborted frame, data=0x81 and valid once.
REQ-029 Send 0x00 then 0xFF back-to-back with zero idle time -> two valid pulses, 160 cycles apart, with data 0x00 then 0xFF.
REQ-030 With UART_RX_PARITY_EN: send 0x07 with parity bit 1 -> valid, data=0x07. Send 0x07 with parity bit 0 -> parity_err pulse, no valid.
